mem_stage: RTL

Memory-access pipeline stage of the LoongArch core, sitting between the execute stage and the write-back stage. It registers the EX-to-MS bus and waits for the data-SRAM response of any load or store that EX issued. It aligns and extends load data and drives the MS-to-WS valid/bus toward write-back. On an exception or ERTN flush from write-back it drops its instruction and discards the orphaned SRAM response.

---
 rtl/mem_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EX instruction until its data-SRAM
// response arrives, aligns load data, and hands the result on to write-back.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_to_ms_valid,
  input  logic [172:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [167:0] ms_to_ws_bus,
  output logic [71:0]  ms_forward,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         excp_flush,
  input  logic         ertn_flush,
  output logic         ms_excp_or_ertn
);

  localparam int unsigned ES_TO_MS_BUS_WD = 173;
  localparam int unsigned MS_TO_WS_BUS_WD = 168;
  localparam int unsigned MS_FORWARD_WD   = 72;
  localparam int unsigned CANCEL_W        = 2;

  typedef struct packed {
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [13:0] csr_num;
    logic        csr_we;
    logic        res_from_csr;
    logic        ertn;
    logic [15:0] excp_num;
    logic        excp;
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  logic                ms_valid_q, ms_valid_d;
  es_bus_t             bus_q, bus_d;
  logic                data_got_q, data_got_d;
  logic [31:0]         rdata_buf_q, rdata_buf_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic        flush, accept, resp_ok, ready_go, cancel_inc, cancel_dec;
  logic [31:0] rdata, load_data, final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Handshake: a response only belongs to this instruction once all orphans are drained.
  always_comb begin
    flush          = excp_flush | ertn_flush;
    resp_ok        = data_sram_data_ok & (cancel_cnt_q == CANCEL_W'(0));
    ready_go       = !bus_q.mem_req | data_got_q | resp_ok;
    ms_allowin     = !ms_valid_q | (ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid_q & ready_go;
    accept         = es_to_ms_valid & ms_allowin & !flush;
    cancel_dec     = data_sram_data_ok & (cancel_cnt_q != CANCEL_W'(0));
    cancel_inc     = flush & ms_valid_q & bus_q.mem_req & !data_got_q & !resp_ok;
  end

  // Next-state logic.
  always_comb begin
    ms_valid_d   = ms_valid_q;
    bus_d        = bus_q;
    data_got_d   = data_got_q;
    rdata_buf_d  = rdata_buf_q;
    cancel_cnt_d = cancel_cnt_q;

    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    if (accept) bus_d = es_bus_t'(es_to_ms_bus);

    if (flush || accept) begin
      data_got_d = 1'b0;
    end else if (ms_valid_q && bus_q.mem_req && !data_got_q && resp_ok && !ws_allowin) begin
      data_got_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    if (cancel_inc && !cancel_dec && cancel_cnt_q != CANCEL_W'(3))
      cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
    else if (cancel_dec && !cancel_inc)
      cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      data_got_q   <= 1'b0;
      rdata_buf_q  <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bus_q        <= bus_d;
      data_got_q   <= data_got_d;
      rdata_buf_q  <= rdata_buf_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  // Load alignment and extension.
  always_comb begin
    rdata = data_got_q ? rdata_buf_q : data_sram_rdata;
    case (bus_q.alu_result[1:0])
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = bus_q.alu_result[1] ? rdata[31:16] : rdata[15:0];
    case (bus_q.ld_op)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_data = {24'd0, ld_byte};
      3'b100:  load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
    final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;
  end

  assign ms_to_ws_bus = MS_TO_WS_BUS_WD'({bus_q.csr_wmask, bus_q.csr_wdata, bus_q.csr_num,
                                          bus_q.csr_we, bus_q.res_from_csr, bus_q.ertn,
                                          bus_q.excp_num, bus_q.excp, bus_q.gr_we, bus_q.dest,
                                          final_result, bus_q.pc});

  assign ms_forward = MS_FORWARD_WD'({ms_valid_q & bus_q.res_from_mem & !ready_go,
                                      bus_q.pc, final_result, bus_q.dest, bus_q.gr_we,
                                      ms_valid_q});

  assign ms_excp_or_ertn = ms_valid_q & (bus_q.excp | bus_q.ertn);

  // Width sanity for the EX payload.
  logic unused_wd;
  assign unused_wd = (ES_TO_MS_BUS_WD == $bits(es_bus_t)) ? 1'b0 : 1'b1;

endmodule
